// File: rtl/mem_access_ctrl_if.sv
// Data-bus bundle between the MEM-stage access controller (master) and
// the data memory or bus fabric (slave).
interface mem_access_ctrl_if;
   logic        bus_req_o;
   logic        bus_we_o;
   logic [31:0] bus_addr_o;
   logic [3:0]  bus_sel_o;
   logic [31:0] bus_wdata_o;
   logic [31:0] bus_rdata_i;
   logic        bus_ack_i;

   modport master (
      output bus_req_o, bus_we_o, bus_addr_o, bus_sel_o, bus_wdata_o,
      input  bus_rdata_i, bus_ack_i
   );

   modport slave (
      input  bus_req_o, bus_we_o, bus_addr_o, bus_sel_o, bus_wdata_o,
      output bus_rdata_i, bus_ack_i
   );
endinterface

// File: rtl/mem_access_ctrl.sv
// MEM-stage load/store controller: stalls the pipeline while a single data-bus
// access runs, formats big-endian load lanes and flags misalignment/timeouts.
module mem_access_ctrl #(
   parameter int BUS_TIMEOUT = 16
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [4:0]                mem_wd_i,
   input  logic                      mem_wreg_i,
   input  logic [31:0]               mem_wdata_i,
   input  logic [7:0]                mem_aluop_i,
   input  logic [31:0]               mem_mem_addr_i,
   input  logic [31:0]               mem_reg2_i,
   output logic [4:0]                wd_o,
   output logic                      wreg_o,
   output logic [31:0]               wdata_o,
   output logic                      stallreq_o,
   output logic                      err_o,
   mem_access_ctrl_if.master         bus
);

   localparam logic [7:0] EXE_LB_OP  = 8'b1110_0000;
   localparam logic [7:0] EXE_LH_OP  = 8'b1110_0001;
   localparam logic [7:0] EXE_LW_OP  = 8'b1110_0011;
   localparam logic [7:0] EXE_LBU_OP = 8'b1110_0100;
   localparam logic [7:0] EXE_LHU_OP = 8'b1110_0101;
   localparam logic [7:0] EXE_SB_OP  = 8'b1110_1000;
   localparam logic [7:0] EXE_SH_OP  = 8'b1110_1001;
   localparam logic [7:0] EXE_SW_OP  = 8'b1110_1011;

   localparam logic [7:0] TMO_LAST = 8'(BUS_TIMEOUT - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_BUSY = 2'b01,
      S_DONE = 2'b10
   } state_t;

   state_t      r_state;
   logic [7:0]  r_cnt;
   logic [7:0]  r_op;
   logic [1:0]  r_addr_lo;
   logic [31:0] r_rdata;
   logic        r_wb_en;
   logic        r_err;
   logic        r_req;
   logic        r_we;
   logic [31:0] r_addr;
   logic [3:0]  r_sel;
   logic [31:0] r_wdata;

   logic        w_is_load;
   logic        w_is_store;
   logic        w_is_mem;
   logic        w_misalign;
   logic [3:0]  w_sel;
   logic [31:0] w_wdata;

   // Pick the addressed lane(s) out of the bus word and extend to 32 bits.
   function automatic logic [31:0] fmt_load(input logic [7:0] op, input logic [1:0] lo,
                                            input logic [31:0] d);
      logic [7:0]  b;
      logic [15:0] h;
      case (lo)
         2'b00:   b = d[31:24];
         2'b01:   b = d[23:16];
         2'b10:   b = d[15:8];
         default: b = d[7:0];
      endcase
      h = lo[1] ? d[15:0] : d[31:16];
      case (op)
         EXE_LB_OP:  fmt_load = {{24{b[7]}}, b};
         EXE_LBU_OP: fmt_load = {24'd0, b};
         EXE_LH_OP:  fmt_load = {{16{h[15]}}, h};
         EXE_LHU_OP: fmt_load = {16'd0, h};
         default:    fmt_load = d;
      endcase
   endfunction

   // Decode the incoming op: kind, alignment, lane select and store data.
   always_comb begin
      w_is_load  = 1'b0;
      w_is_store = 1'b0;
      w_misalign = 1'b0;
      w_sel      = 4'b0000;
      w_wdata    = 32'd0;
      case (mem_aluop_i)
         EXE_LB_OP, EXE_LBU_OP: begin
            w_is_load = 1'b1;
            w_sel     = 4'b1000 >> mem_mem_addr_i[1:0];
         end
         EXE_LH_OP, EXE_LHU_OP: begin
            w_is_load  = 1'b1;
            w_misalign = mem_mem_addr_i[0];
            w_sel      = mem_mem_addr_i[1] ? 4'b0011 : 4'b1100;
         end
         EXE_LW_OP: begin
            w_is_load  = 1'b1;
            w_misalign = |mem_mem_addr_i[1:0];
            w_sel      = 4'b1111;
         end
         EXE_SB_OP: begin
            w_is_store = 1'b1;
            w_sel      = 4'b1000 >> mem_mem_addr_i[1:0];
            w_wdata    = {4{mem_reg2_i[7:0]}};
         end
         EXE_SH_OP: begin
            w_is_store = 1'b1;
            w_misalign = mem_mem_addr_i[0];
            w_sel      = mem_mem_addr_i[1] ? 4'b0011 : 4'b1100;
            w_wdata    = {2{mem_reg2_i[15:0]}};
         end
         EXE_SW_OP: begin
            w_is_store = 1'b1;
            w_misalign = |mem_mem_addr_i[1:0];
            w_sel      = 4'b1111;
            w_wdata    = mem_reg2_i;
         end
         default: begin
            w_is_store = 1'b0;
         end
      endcase
   end

   assign w_is_mem = w_is_load | w_is_store;

   // Access FSM; all bus outputs and the error pulse are registered here.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state   <= S_IDLE;
         r_cnt     <= 8'd0;
         r_op      <= 8'd0;
         r_addr_lo <= 2'b00;
         r_rdata   <= 32'd0;
         r_wb_en   <= 1'b0;
         r_err     <= 1'b0;
         r_req     <= 1'b0;
         r_we      <= 1'b0;
         r_addr    <= 32'd0;
         r_sel     <= 4'b0000;
         r_wdata   <= 32'd0;
      end else begin
         r_err <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_is_mem) begin
                  r_op      <= mem_aluop_i;
                  r_addr_lo <= mem_mem_addr_i[1:0];
                  r_cnt     <= 8'd0;
                  if (w_misalign) begin
                     r_state <= S_DONE;
                     r_wb_en <= 1'b0;
                     r_err   <= 1'b1;
                  end else begin
                     r_state <= S_BUSY;
                     r_req   <= 1'b1;
                     r_we    <= w_is_store;
                     r_addr  <= {mem_mem_addr_i[31:2], 2'b00};
                     r_sel   <= w_sel;
                     r_wdata <= w_wdata;
                  end
               end else begin
                  r_state <= S_IDLE;
               end
            end
            S_BUSY: begin
               if (bus.bus_ack_i) begin
                  r_state <= S_DONE;
                  r_req   <= 1'b0;
                  r_we    <= 1'b0;
                  r_sel   <= 4'b0000;
                  r_rdata <= fmt_load(r_op, r_addr_lo, bus.bus_rdata_i);
                  r_wb_en <= ~r_we;
               end else if (r_cnt == TMO_LAST) begin
                  r_state <= S_DONE;
                  r_req   <= 1'b0;
                  r_we    <= 1'b0;
                  r_sel   <= 4'b0000;
                  r_wb_en <= 1'b0;
                  r_err   <= 1'b1;
               end else begin
                  r_cnt <= r_cnt + 8'd1;
               end
            end
            S_DONE: begin
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.bus_req_o   = r_req;
   assign bus.bus_we_o    = r_we;
   assign bus.bus_addr_o  = r_addr;
   assign bus.bus_sel_o   = r_sel;
   assign bus.bus_wdata_o = r_wdata;
   assign err_o           = r_err;

   // Write-back and stall: pass-through in IDLE, captured result in DONE.
   always_comb begin
      wd_o       = mem_wd_i;
      wreg_o     = 1'b0;
      wdata_o    = mem_wdata_i;
      stallreq_o = 1'b0;
      if (!rst) begin
         wreg_o     = 1'b0;
         stallreq_o = 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_is_mem) begin
                  stallreq_o = 1'b1;
               end else begin
                  wreg_o = mem_wreg_i;
               end
            end
            S_BUSY: begin
               stallreq_o = 1'b1;
            end
            S_DONE: begin
               wreg_o  = r_wb_en;
               wdata_o = r_rdata;
            end
            default: begin
               stallreq_o = 1'b0;
            end
         endcase
      end
   end

endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 Parameter: BUS_TIMEOUT, 16, number of BUSY cycles without bus_ack_i before the access is aborted; legal range 2..255.
REQ-002 clk  in  1  single clock; all state changes on rising edge.
REQ-003 rst  in  1  asynchronous, active-low reset.
REQ-004 mem_wd_i  in  5  destination register address from the EX/MEM register.
REQ-005 mem_wreg_i  in  1  register write enable from the EX/MEM register.
REQ-006 mem_wdata_i  in  32  ALU result from the EX/MEM register.
REQ-007 mem_aluop_i  in  8  operation code, AluOpBus encoding.
REQ-008 mem_mem_addr_i  in  32  effective byte address.
REQ-009 mem_reg2_i  in  32  store source operand.
REQ-010 wd_o  out  5  destination register address to MEM/WB.
REQ-011 wreg_o  out  1  register write enable to MEM/WB.
REQ-012 wdata_o  out  32  write-back data to MEM/WB.
REQ-013 stallreq_o  out  1  stall request to the pipeline controller, MEM stage.
REQ-014 bus_req_o  out  1  data bus request.
REQ-015 bus_we_o  out  1  data bus write enable: 1 = store.
REQ-016 bus_addr_o  out  32  word-aligned bus address, {addr[31:2],2'b00}.
REQ-017 bus_sel_o  out  4  byte-lane select; bit 3 = bits 31:24.
REQ-018 bus_wdata_o  out  32  store data.
REQ-019 bus_rdata_i  in  32  load data, valid when bus_ack_i = 1.
REQ-020 bus_ack_i  in  1  transfer complete.
REQ-021 err_o  out  1  one-cycle pulse on misaligned access or timeout.

Function
REQ-022 Memory ops SHALL be EXE_LB_OP, EXE_LBU_OP, EXE_LH_OP, EXE_LHU_OP, EXE_LW_OP, EXE_SB_OP, EXE_SH_OP and EXE_SW_OP; every other aluop is a non-memory op.
REQ-023 Non-memory op in IDLE: wd_o/wreg_o/wdata_o SHALL equal the inputs combinationally; stallreq_o = 0; no bus activity.
REQ-024 FSM states SHALL be IDLE, BUSY and DONE.
REQ-025 IDLE with an aligned memory op:
- stallreq_o = 1 combinationally.
- Next edge: enter BUSY and register bus_req_o = 1, bus_we_o, bus_addr_o, bus_sel_o and bus_wdata_o.
- Clear the timeout counter.
REQ-026 BUSY: stallreq_o = 1 and bus outputs held stable; bus_ack_i = 1 SHALL end the access on that edge.
- On ack: deassert bus_req_o, capture the formatted load result, enter DONE.
- An ack in the first BUSY cycle is valid.
REQ-027 DONE (exactly one cycle):
- stallreq_o = 0; wd_o = mem_wd_i.
- Load: wreg_o = 1, wdata_o = captured result.
- Store: wreg_o = 0.
- Next state is always IDLE, regardless of mem_aluop_i.
REQ-028 Lane select and data for byte ops (big-endian lanes):
- addr[1:0] 00/01/10/11 → bus_sel_o 1000/0100/0010/0001.
- SB data = {4{reg2[7:0]}}.
REQ-029 Lane select and data for halfword and word ops:
- Halfword: addr[1] 0 → sel 1100, 1 → sel 0011; SH data = {2{reg2[15:0]}}.
- Word: sel 1111; SW data = reg2.
REQ-030 Loads SHALL take the selected lane(s) of bus_rdata_i.
- LB/LH sign-extend to 32 bits.
- LBU/LHU zero-extend.
REQ-031 Misaligned access (LH/LHU/SH with addr[0] = 1, or LW/SW with addr[1:0] ≠ 00) in IDLE: no bus request; go directly to DONE with wreg_o = 0 in DONE; err_o pulses for one cycle in DONE.
REQ-032 Timeout: counter increments each BUSY cycle without ack. When it reaches BUSY_TIMEOUT-1 without ack, that edge SHALL:
- deassert bus_req_o;
- enter DONE with wreg_o = 0;
- pulse err_o for one cycle in DONE.
REQ-033 bus_ack_i SHALL be ignored in IDLE and DONE.
REQ-034 bus_req_o, bus_we_o, bus_addr_o, bus_sel_o and bus_wdata_o SHALL be register outputs.
- bus_sel_o and bus_we_o are 0 whenever bus_req_o = 0.

Reset
REQ-035 rst = 0 SHALL immediately force:
- state IDLE;
- bus_req_o, bus_we_o, bus_sel_o, err_o = 0;
- bus_addr_o, bus_wdata_o, captured result, timeout counter = 0.
REQ-036 Reset asserted in BUSY SHALL abort the access; no write-back; bus_req_o falls asynchronously.
REQ-037 While rst = 0, stallreq_o = 0 and wreg_o = 0.

Verification
REQ-038 LW, addr 0x100, ack on 3rd BUSY cycle with rdata 0x12345678 → stallreq_o high 4 cycles; DONE shows wreg_o = 1, wdata_o = 0x12345678.
REQ-039 LB, addr 0x103, rdata 0x000000F0 → bus_sel_o = 0001, wdata_o = 0xFFFFFFF0; same with LBU → 0x000000F0.
REQ-040 SH, addr 0x202, reg2 0xAAAABEEF → bus_we_o = 1, bus_sel_o = 0011, bus_wdata_o = 0xBEEFBEEF, bus_addr_o = 0x200; DONE shows wreg_o = 0.
REQ-041 LW, addr 0x101 → no bus_req_o, one stall cycle, err_o pulse, wreg_o = 0.
REQ-042 SW with ack never asserted, BUS_TIMEOUT = 16 → bus_req_o high exactly 16 cycles, then err_o pulse and return to IDLE.
REQ-043 rst low during BUSY → bus_req_o = 0 without waiting for a clock edge; after release, a non-memory op passes through with stallreq_o = 0.
